// File: rtl/updown_counter_ext.sv
// Up/down counter with programmable bounds and step, wrap / saturate / one-shot modes,
// registered terminal-count pulse and sticky overflow flag.
module updown_counter_ext #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [1:0]        mode,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  q_out,
  output logic              tc,
  output logic              ovf,
  output logic              halted,
  output logic              at_min,
  output logic              at_max,
  output logic              cfg_err
);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_WRAP_B  = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             ovf_r;
  logic             halted_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_nxt_s;
  logic             halted_nxt_s;

  logic [WIDTH:0]   step_ext_s;
  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   min_plus_s;
  logic [WIDTH-1:0] dn_val_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic             step_nz_s;
  logic             cross_s;
  logic             count_en_s;
  logic             fire_s;
  logic             cfg_err_s;

  // Widened unsigned arithmetic so neither direction can wrap before the crossing test.
  always_comb begin
    step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    q_ext_s    = {1'b0, q_r};
    up_sum_s   = q_ext_s + step_ext_s;
    min_plus_s = {1'b0, min_val} + step_ext_s;
    dn_val_s   = q_r - step_ext_s[WIDTH-1:0];
    step_nz_s  = (step != {STEP_W{1'b0}});
    cfg_err_s  = (min_val > max_val);
    if (!step_nz_s) begin
      cross_s = 1'b0;
    end else if (up_down) begin
      cross_s = (up_sum_s > {1'b0, max_val});
    end else begin
      cross_s = (q_ext_s < min_plus_s);
    end
    if (load_val < min_val) begin
      load_clamped_s = min_val;
    end else if (load_val > max_val) begin
      load_clamped_s = max_val;
    end else begin
      load_clamped_s = load_val;
    end
    count_en_s = en & ~cfg_err_s & ~(halted_r & (mode == MODE_ONESHOT));
    fire_s     = ~clr & ~load & count_en_s & cross_s;
  end

  // Next-state selection: clr > load > count; tc is a one-cycle pulse.
  always_comb begin
    q_nxt_s      = q_r;
    tc_nxt_s     = 1'b0;
    halted_nxt_s = halted_r;
    if (clr) begin
      q_nxt_s      = min_val;
      halted_nxt_s = 1'b0;
    end else if (load) begin
      q_nxt_s      = load_clamped_s;
      halted_nxt_s = 1'b0;
    end else if (count_en_s) begin
      if (cross_s) begin
        tc_nxt_s = 1'b1;
        case (mode)
          MODE_SAT: begin
            q_nxt_s = up_down ? max_val : min_val;
          end
          MODE_ONESHOT: begin
            q_nxt_s      = up_down ? max_val : min_val;
            halted_nxt_s = 1'b1;
          end
          MODE_WRAP, MODE_WRAP_B: begin
            q_nxt_s = up_down ? min_val : max_val;
          end
          default: begin
            q_nxt_s = up_down ? min_val : max_val;
          end
        endcase
      end else if (up_down) begin
        q_nxt_s = up_sum_s[WIDTH-1:0];
      end else begin
        q_nxt_s = dn_val_s;
      end
    end else begin
      q_nxt_s = q_r;
    end
    if (mode != MODE_ONESHOT) begin
      halted_nxt_s = 1'b0;
    end else begin
      halted_nxt_s = halted_nxt_s;
    end
  end

  // Sticky overflow: a crossing in the same cycle as ovf_clr keeps it set.
  always_comb begin
    if (fire_s) begin
      ovf_nxt_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r      <= {WIDTH{1'b0}};
      tc_r     <= 1'b0;
      ovf_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      q_r      <= q_nxt_s;
      tc_r     <= tc_nxt_s;
      ovf_r    <= ovf_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  assign q_out   = q_r;
  assign tc      = tc_r;
  assign ovf     = ovf_r;
  assign halted  = halted_r;
  assign at_min  = (q_r == min_val);
  assign at_max  = (q_r == max_val);
  assign cfg_err = cfg_err_s;

endmodule

// File: tb/tb_updown_counter_ext.sv
// Directed bench for updown_counter_ext (WIDTH = 8, STEP_W = 4) with hand-computed expectations.
module tb_updown_counter_ext;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       up_down;
  logic [3:0] step;
  logic [7:0] min_val;
  logic [7:0] max_val;
  logic [1:0] mode;
  logic       ovf_clr;
  logic [7:0] q_out;
  logic       tc;
  logic       ovf;
  logic       halted;
  logic       at_min;
  logic       at_max;
  logic       cfg_err;

  int n_tests;
  int n_fail;

  updown_counter_ext #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_down(up_down), .step(step), .min_val(min_val), .max_val(max_val),
    .mode(mode), .ovf_clr(ovf_clr), .q_out(q_out), .tc(tc), .ovf(ovf),
    .halted(halted), .at_min(at_min), .at_max(at_max), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q_tc(input string tag, input logic [7:0] q_e, input logic tc_e);
    check({tag, ".q"}, {24'd0, q_out}, {24'd0, q_e});
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, tc_e});
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0; en = 1'b0;
    up_down = 1'b1; step = 4'd1; min_val = 8'd0; max_val = 8'd255;
    mode = 2'b00; ovf_clr = 1'b0;
    #3;
    check("rst.q", {24'd0, q_out}, 32'd0);
    check("rst.tc", {31'd0, tc}, 32'd0);
    check("rst.ovf", {31'd0, ovf}, 32'd0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: wrap up, step 1, full range
    load = 1'b1; load_val = 8'd254; tick(); load = 1'b0;
    chk_q_tc("t1.load", 8'd254, 1'b0);
    en = 1'b1; tick();
    chk_q_tc("t1.c1", 8'd255, 1'b0);
    check("t1.ovf0", {31'd0, ovf}, 32'd0);
    tick();
    chk_q_tc("t1.wrap", 8'd0, 1'b1);
    check("t1.ovf1", {31'd0, ovf}, 32'd1);
    en = 1'b0; tick();
    chk_q_tc("t1.idle", 8'd0, 1'b0);
    check("t1.ovf_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t1.ovf_clr", {31'd0, ovf}, 32'd0);

    // 2: saturate, step 3, [10,20]
    mode = 2'b01; step = 4'd3; min_val = 8'd10; max_val = 8'd20;
    load = 1'b1; load_val = 8'd15; tick(); load = 1'b0;
    check("t2.load", {24'd0, q_out}, 32'd15);
    en = 1'b1; tick();
    chk_q_tc("t2.c1", 8'd18, 1'b0);
    tick();
    chk_q_tc("t2.sat1", 8'd20, 1'b1);
    check("t2.at_max", {31'd0, at_max}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk_q_tc("t2.sat2", 8'd20, 1'b1);
    check("t2.ovf_set_wins", {31'd0, ovf}, 32'd1);
    en = 1'b0; load = 1'b1; load_val = 8'd12; tick(); load = 1'b0;
    chk_q_tc("t2.load12", 8'd12, 1'b0);
    up_down = 1'b0; en = 1'b1; tick(); en = 1'b0;
    chk_q_tc("t2.sat_dn", 8'd10, 1'b1);
    check("t2.at_min", {31'd0, at_min}, 32'd1);

    // 3: wrap down, step 2, [5,9]
    mode = 2'b00; step = 4'd2; min_val = 8'd5; max_val = 8'd9;
    load = 1'b1; load_val = 8'd6; tick(); load = 1'b0;
    check("t3.load", {24'd0, q_out}, 32'd6);
    en = 1'b1; tick();
    chk_q_tc("t3.w1", 8'd9, 1'b1);
    tick();
    chk_q_tc("t3.c7", 8'd7, 1'b0);
    tick();
    chk_q_tc("t3.c5", 8'd5, 1'b0);
    tick();
    chk_q_tc("t3.w2", 8'd9, 1'b1);
    step = 4'd0; tick();
    chk_q_tc("t3.step0", 8'd9, 1'b0);
    en = 1'b0;

    // 4: one-shot up, step 4
    mode = 2'b10; up_down = 1'b1; step = 4'd4; min_val = 8'd0; max_val = 8'd255;
    load = 1'b1; load_val = 8'd250; tick(); load = 1'b0;
    check("t4.load", {24'd0, q_out}, 32'd250);
    en = 1'b1; tick();
    chk_q_tc("t4.c1", 8'd254, 1'b0);
    tick();
    chk_q_tc("t4.end", 8'd255, 1'b1);
    check("t4.halted", {31'd0, halted}, 32'd1);
    tick();
    chk_q_tc("t4.hold", 8'd255, 1'b0);
    check("t4.halted_hold", {31'd0, halted}, 32'd1);
    load = 1'b1; load_val = 8'd0; tick(); load = 1'b0;
    check("t4.reload", {24'd0, q_out}, 32'd0);
    check("t4.unhalt", {31'd0, halted}, 32'd0);
    tick();
    chk_q_tc("t4.resume", 8'd4, 1'b0);

    // 5: priority and clamp
    mode = 2'b00; step = 4'd1; min_val = 8'd10; max_val = 8'd50;
    clr = 1'b1; load = 1'b1; load_val = 8'd100; tick(); clr = 1'b0;
    check("t5.clr_pri", {24'd0, q_out}, 32'd10);
    load_val = 8'd3; tick();
    check("t5.clamp_lo", {24'd0, q_out}, 32'd10);
    load_val = 8'd200; tick(); load = 1'b0; en = 1'b0;
    check("t5.clamp_hi", {24'd0, q_out}, 32'd50);

    // 6: bad config freezes counting, then async reset mid-count
    min_val = 8'd30; max_val = 8'd20; en = 1'b1; #1;
    check("t6.cfg_err", {31'd0, cfg_err}, 32'd1);
    tick();
    chk_q_tc("t6.frozen", 8'd50, 1'b0);
    min_val = 8'd0; max_val = 8'd51; tick();
    chk_q_tc("t6.c51", 8'd51, 1'b0);
    tick();
    chk_q_tc("t6.wrap", 8'd0, 1'b1);
    check("t6.ovf", {31'd0, ovf}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6.arst.q", {24'd0, q_out}, 32'd0);
    check("t6.arst.tc", {31'd0, tc}, 32'd0);
    check("t6.arst.ovf", {31'd0, ovf}, 32'd0);
    check("t6.arst.halted", {31'd0, halted}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
